// File: rtl/cba_region_tot_arbiter.sv
// cba_region_tot_arbiter
//   Region readout controller for a group of CBA pixel front-ends. Each
//   pixel's ToT is latched into a pending slot on its save pulse and
//   stamped with the bunch-crossing counter. Pending slots are drained
//   round-robin, one per cycle, into a first-word-fallthrough FIFO that
//   feeds the core readout over valid/ready.
//
// Ports
//   Clk           single clock, posedge
//   Reset_b       asynchronous active-low reset
//   Enable        capture enable; save pulses ignored (and not counted) when low
//   TotSavePulse  [NPIX]           per-pixel save strobe
//   ToT           [NPIX*TOT_BITS]  per-pixel ToT, pixel i at [i*TOT_BITS +: TOT_BITS]
//   DataOut       {ts, pix_id, tot} at FIFO head
//   DataValid     FIFO non-empty
//   DataReady     consumer accept
//   DropCnt       saturating count of hits lost to a busy slot
//   Busy          any slot pending or FIFO non-empty

`ifndef CBA_TOT_BITS
`define CBA_TOT_BITS 4
`endif

// Per-pixel pending slot. A capture takes priority over a clear so that a
// pulse landing on the grant edge is kept as the next hit.
module cba_pix_slot #(
    parameter int TOT_BITS = 4,
    parameter int TS_BITS  = 8
) (
    input  logic                Clk,
    input  logic                Reset_b,
    input  logic                cap,
    input  logic                clr,
    input  logic [TOT_BITS-1:0] tot_in,
    input  logic [TS_BITS-1:0]  ts_in,
    output logic                pend,
    output logic [TOT_BITS-1:0] tot,
    output logic [TS_BITS-1:0]  ts
);
    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            pend <= 1'b0;
            tot  <= '0;
            ts   <= '0;
        end else if (cap) begin
            pend <= 1'b1;
            tot  <= tot_in;
            ts   <= ts_in;
        end else if (clr) begin
            pend <= 1'b0;
        end
    end
endmodule

module cba_region_tot_arbiter #(
    parameter int NPIX     = 4,
    parameter int TOT_BITS = `CBA_TOT_BITS,
    parameter int TS_BITS  = 8,
    parameter int DEPTH    = 4,
    localparam int PIX_W   = $clog2(NPIX),
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int W       = TS_BITS + PIX_W + TOT_BITS
) (
    input  logic                     Clk,
    input  logic                     Reset_b,
    input  logic                     Enable,
    input  logic [NPIX-1:0]          TotSavePulse,
    input  logic [NPIX*TOT_BITS-1:0] ToT,
    output logic [W-1:0]             DataOut,
    output logic                     DataValid,
    input  logic                     DataReady,
    output logic [7:0]               DropCnt,
    output logic                     Busy
);
    logic [NPIX-1:0]                pend;
    logic [NPIX-1:0][TOT_BITS-1:0]  pend_tot;
    logic [NPIX-1:0][TS_BITS-1:0]   pend_ts;
    logic [NPIX-1:0]                cap;
    logic [NPIX-1:0]                drop;
    logic [NPIX-1:0]                gnt_vec;

    logic [TS_BITS-1:0]             bcid;
    logic [PIX_W-1:0]               rr;
    logic                           gnt_vld;
    logic [PIX_W-1:0]               gnt_id;

    logic [DEPTH-1:0][W-1:0]        mem;
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic [PTR_W:0]                 count;
    logic                           full;
    logic                           push;
    logic                           pop;

    logic [PIX_W:0]                 drop_n;
    logic [8:0]                     drop_sum;

    // Full is taken from the registered count only; a same-cycle pop does
    // not open a slot for a grant.
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign DataValid = (count != '0);
    assign push      = gnt_vld;
    assign pop       = DataValid & DataReady;
    assign DataOut   = mem[rd_ptr];
    assign Busy      = (|pend) | DataValid;

    // Round-robin search from rr. Walking k downward lets the lowest offset
    // be the last (winning) assignment.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        if (!full) begin
            for (int k = NPIX-1; k >= 0; k--) begin
                if (pend[rr + PIX_W'(k)]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = rr + PIX_W'(k);
                end
            end
        end
    end

    assign gnt_vec = NPIX'(gnt_vld) << gnt_id;

    // A slot being granted this cycle is free for a new capture.
    always_comb begin
        for (int i = 0; i < NPIX; i++) begin
            cap[i]  = Enable & TotSavePulse[i] & (~pend[i] | gnt_vec[i]);
            drop[i] = Enable & TotSavePulse[i] &   pend[i] & ~gnt_vec[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPIX; gi++) begin : g_slot
            cba_pix_slot #(
                .TOT_BITS (TOT_BITS),
                .TS_BITS  (TS_BITS)
            ) u_slot (
                .Clk     (Clk),
                .Reset_b (Reset_b),
                .cap     (cap[gi]),
                .clr     (gnt_vec[gi]),
                .tot_in  (ToT[gi*TOT_BITS +: TOT_BITS]),
                .ts_in   (bcid),
                .pend    (pend[gi]),
                .tot     (pend_tot[gi]),
                .ts      (pend_ts[gi])
            );
        end
    endgenerate

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NPIX; i++) drop_n = drop_n + (PIX_W+1)'(drop[i]);
    end

    assign drop_sum = {1'b0, DropCnt} + 9'(drop_n);

    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            bcid    <= '0;
            rr      <= '0;
            DropCnt <= '0;
        end else begin
            bcid    <= bcid + 1'b1;
            if (gnt_vld) rr <= gnt_id + 1'b1;
            DropCnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // FWFT FIFO; memory is cleared on reset so DataOut reads 0 from reset.
    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {pend_ts[gnt_id], gnt_id, pend_tot[gnt_id]};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_cba_region_tot_arbiter.sv
module tb_cba_region_tot_arbiter;
    logic        Clk;
    logic        Reset_b;
    logic        Enable;
    logic [3:0]  TotSavePulse;
    logic [15:0] ToT;
    logic [13:0] DataOut;
    logic        DataValid;
    logic        DataReady;
    logic [7:0]  DropCnt;
    logic        Busy;

    int n_cmp = 0;
    int n_err = 0;

    cba_region_tot_arbiter #(
        .NPIX     (4),
        .TOT_BITS (4),
        .TS_BITS  (8),
        .DEPTH    (4)
    ) dut (
        .Clk          (Clk),
        .Reset_b      (Reset_b),
        .Enable       (Enable),
        .TotSavePulse (TotSavePulse),
        .ToT          (ToT),
        .DataOut      (DataOut),
        .DataValid    (DataValid),
        .DataReady    (DataReady),
        .DropCnt      (DropCnt),
        .Busy         (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [13:0] mk(input int ts, input int pix, input int tot);
        logic [7:0] t8;
        logic [1:0] p2;
        logic [3:0] v4;
        t8 = ts[7:0];
        p2 = pix[1:0];
        v4 = tot[3:0];
        return {t8, p2, v4};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Leaves reset released 1ns after a posedge; next posedge is E0 with bcid=0.
    task automatic do_reset();
        Reset_b      = 1'b0;
        TotSavePulse = '0;
        ToT          = '0;
        Enable       = 1'b1;
        DataReady    = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_b = 1'b1;
    endtask

    task automatic test_reset();
        Reset_b = 1'b0; Enable = 1'b1; TotSavePulse = '0; ToT = '0; DataReady = 1'b0;
        #3;
        n_cmp++; if (DataValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", DataValid); end
        n_cmp++; if (DataOut !== 14'h0) begin n_err++; $display("FAIL reset_dataout: got %h expected 0", DataOut); end
        n_cmp++; if (DropCnt !== 8'd0) begin n_err++; $display("FAIL reset_dropcnt: got %0d expected 0", DropCnt); end
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    endtask

    task automatic test_single_hit();
        do_reset();
        // disabled pulse is ignored
        Enable = 1'b0; TotSavePulse = 4'b0001; ToT = 16'h0005;
        tick();                                   // E0
        TotSavePulse = '0; Enable = 1'b1;
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL enable_low_busy: got %b expected 0", Busy); end
        repeat (4) tick();                        // E1..E4, bcid=5
        DataReady = 1'b1; TotSavePulse = 4'b0100; ToT = 16'h0900;
        tick();                                   // E5 capture, ts=5
        TotSavePulse = '0;
        n_cmp++; if (DataValid !== 1'b0 || Busy !== 1'b1) begin n_err++; $display("FAIL single_pending: got valid=%b busy=%b expected valid=0 busy=1", DataValid, Busy); end
        tick();                                   // E6 grant
        n_cmp++; if (DataValid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", DataValid); end
        n_cmp++; if (DataOut !== mk(5, 2, 9)) begin n_err++; $display("FAIL single_word: got %h expected %h", DataOut, mk(5, 2, 9)); end
        tick();                                   // E7 pop
        n_cmp++; if (DataValid !== 1'b0 || Busy !== 1'b0) begin n_err++; $display("FAIL single_drained: got valid=%b busy=%b expected 0 0", DataValid, Busy); end
    endtask

    task automatic test_round_robin();
        logic [13:0] exp_w [4];
        exp_w[0] = mk(0, 0, 1); exp_w[1] = mk(0, 1, 2);
        exp_w[2] = mk(0, 2, 3); exp_w[3] = mk(0, 3, 4);
        do_reset();
        DataReady = 1'b1; TotSavePulse = 4'b1111; ToT = {4'd4, 4'd3, 4'd2, 4'd1};
        tick();                                   // E0
        TotSavePulse = '0;
        for (int i = 0; i < 4; i++) begin
            tick();                               // E1..E4
            n_cmp++; if (DataValid !== 1'b1 || DataOut !== exp_w[i]) begin n_err++; $display("FAIL rr_word%0d: got valid=%b %h expected %h", i, DataValid, DataOut, exp_w[i]); end
        end
        tick();                                   // E5, bcid=6
        n_cmp++; if (DataValid !== 1'b0) begin n_err++; $display("FAIL rr_empty: got %b expected 0", DataValid); end
        TotSavePulse = 4'b0011; ToT = {4'd0, 4'd0, 4'd6, 4'd5};
        tick();                                   // E6 capture ts=6
        TotSavePulse = '0;
        tick();
        n_cmp++; if (DataOut !== mk(6, 0, 5)) begin n_err++; $display("FAIL rr_wrap_first: got %h expected %h", DataOut, mk(6, 0, 5)); end
        tick();
        n_cmp++; if (DataOut !== mk(6, 1, 6)) begin n_err++; $display("FAIL rr_wrap_second: got %h expected %h", DataOut, mk(6, 1, 6)); end
        tick();
    endtask

    task automatic test_backpressure();
        int          pix [6];
        logic [13:0] exp_w [6];
        pix = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 6; i++) exp_w[i] = mk(i, pix[i], i + 1);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            TotSavePulse = 4'(1 << pix[i]);
            ToT = 16'((i + 1) << (4 * pix[i]));
            tick();                               // E0..E5
        end
        TotSavePulse = '0;
        n_cmp++; if (DataValid !== 1'b1 || Busy !== 1'b1 || DropCnt !== 8'd0) begin n_err++; $display("FAIL bp_full_state: got valid=%b busy=%b drop=%0d expected 1 1 0", DataValid, Busy, DropCnt); end
        repeat (2) tick();
        n_cmp++; if (DataOut !== exp_w[0]) begin n_err++; $display("FAIL bp_head_hold: got %h expected %h", DataOut, exp_w[0]); end
        DataReady = 1'b1;
        for (int i = 1; i < 6; i++) begin
            tick();
            n_cmp++; if (DataValid !== 1'b1 || DataOut !== exp_w[i]) begin n_err++; $display("FAIL bp_word%0d: got valid=%b %h expected %h", i, DataValid, DataOut, exp_w[i]); end
        end
        tick();
        n_cmp++; if (DataValid !== 1'b0 || Busy !== 1'b0 || DropCnt !== 8'd0) begin n_err++; $display("FAIL bp_drained: got valid=%b busy=%b drop=%0d expected 0 0 0", DataValid, Busy, DropCnt); end
    endtask

    task automatic test_drop();
        logic [13:0] exp_w [4];
        exp_w[0] = mk(0, 1, 2); exp_w[1] = mk(0, 2, 3);
        exp_w[2] = mk(0, 3, 4); exp_w[3] = mk(5, 1, 10);
        do_reset();
        TotSavePulse = 4'b1111; ToT = {4'd4, 4'd3, 4'd2, 4'd1};
        tick();                                   // E0
        TotSavePulse = '0;
        repeat (4) tick();                        // E1..E4 fill FIFO
        TotSavePulse = 4'b0010; ToT = 16'h00A0;
        tick();                                   // E5 capture pix1, ts=5
        ToT = 16'h00B0; tick();                   // E6 drop
        ToT = 16'h00C0; tick();                   // E7 drop
        ToT = 16'h00D0; tick();                   // E8 drop
        TotSavePulse = '0;
        n_cmp++; if (DropCnt !== 8'd3) begin n_err++; $display("FAIL drop_three: got %0d expected 3", DropCnt); end
        n_cmp++; if (DataOut !== mk(0, 0, 1)) begin n_err++; $display("FAIL drop_head: got %h expected %h", DataOut, mk(0, 0, 1)); end
        DataReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (DataValid !== 1'b1 || DataOut !== exp_w[i]) begin n_err++; $display("FAIL drop_word%0d: got valid=%b %h expected %h", i, DataValid, DataOut, exp_w[i]); end
        end
        tick();
        n_cmp++; if (DataValid !== 1'b0) begin n_err++; $display("FAIL drop_drained: got %b expected 0", DataValid); end
        DataReady = 1'b0; TotSavePulse = 4'b1111; ToT = 16'h1111;
        repeat (80) tick();
        TotSavePulse = '0;
        n_cmp++; if (DropCnt !== 8'd255) begin n_err++; $display("FAIL drop_saturate: got %0d expected 255", DropCnt); end
    endtask

    task automatic test_recapture();
        do_reset();
        DataReady = 1'b1; TotSavePulse = 4'b1000; ToT = 16'h2000;
        tick();                                   // E0 capture ts=0
        ToT = 16'h7000;
        tick();                                   // E1 grant + recapture ts=1
        TotSavePulse = '0;
        n_cmp++; if (DataOut !== mk(0, 3, 2) || DataValid !== 1'b1) begin n_err++; $display("FAIL recap_old: got valid=%b %h expected %h", DataValid, DataOut, mk(0, 3, 2)); end
        tick();
        n_cmp++; if (DataOut !== mk(1, 3, 7) || DataValid !== 1'b1) begin n_err++; $display("FAIL recap_new: got valid=%b %h expected %h", DataValid, DataOut, mk(1, 3, 7)); end
        tick();
        n_cmp++; if (DropCnt !== 8'd0 || Busy !== 1'b0) begin n_err++; $display("FAIL recap_nodrop: got drop=%0d busy=%b expected 0 0", DropCnt, Busy); end
    endtask

    task automatic test_reset_wrap();
        do_reset();
        TotSavePulse = 4'b0111; ToT = {4'd0, 4'd3, 4'd2, 4'd1};
        tick();
        TotSavePulse = '0;
        repeat (3) tick();
        n_cmp++; if (DataValid !== 1'b1) begin n_err++; $display("FAIL rst_queued: got %b expected 1", DataValid); end
        #2;
        Reset_b = 1'b0;
        #1;
        n_cmp++; if (DataValid !== 1'b0 || Busy !== 1'b0) begin n_err++; $display("FAIL rst_async: got valid=%b busy=%b expected 0 0", DataValid, Busy); end
        n_cmp++; if (DataOut !== 14'h0 || DropCnt !== 8'd0) begin n_err++; $display("FAIL rst_outputs: got %h drop=%0d expected 0 0", DataOut, DropCnt); end
        @(posedge Clk);
        #1;
        Reset_b = 1'b1;
        repeat (256) tick();                      // bcid back to 0
        n_cmp++; if (DataValid !== 1'b0 || Busy !== 1'b0) begin n_err++; $display("FAIL rst_no_partial: got valid=%b busy=%b expected 0 0", DataValid, Busy); end
        DataReady = 1'b1; TotSavePulse = 4'b0010; ToT = 16'h0050;
        tick();
        TotSavePulse = '0;
        tick();
        n_cmp++; if (DataValid !== 1'b1 || DataOut !== mk(0, 1, 5)) begin n_err++; $display("FAIL wrap_ts: got valid=%b %h expected %h", DataValid, DataOut, mk(0, 1, 5)); end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_round_robin();
        test_backpressure();
        test_drop();
        test_recapture();
        test_reset_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
